// File: rtl/mem_array_reader_if.sv
// Bus between the capture-array reader, the array/writer side and the downstream consumer.
// The reader uses the master view; the environment (array, writer, consumer) uses the slave view.
interface mem_array_reader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        input  wr_en,
        input  wr_addr,
        input  mem_rd_data,
        input  out_ready,
        output mem_rd_addr,
        output out_data,
        output out_valid
    );

    modport slave (
        output wr_en,
        output wr_addr,
        output mem_rd_data,
        output out_ready,
        input  mem_rd_addr,
        input  out_data,
        input  out_valid
    );
endinterface

// File: rtl/mem_array_reader.sv
// Drains the circular capture array oldest-first into a registered valid/ready stream,
// tracking occupancy, dropping the oldest byte on overrun and flagging writer pointer desync.
module mem_array_reader #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_array_reader_if.master  bus,
    input  logic                clr_flags,
    output logic [ADDR_W:0]     level,
    output logic                overrun,
    output logic                ptr_err
);
    localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              overrun_q, overrun_d;
    logic              ptr_err_q, ptr_err_d;

    logic              pop;
    logic              load;
    logic              drop;
    logic [ADDR_W-1:0] wr_expected;
    logic              ptr_mismatch;

    always_comb begin
        pop          = out_valid_q & bus.out_ready;
        load         = (~out_valid_q | pop) & (level_q != '0);
        // A write into a full array with nothing leaving overwrites the oldest unread byte.
        drop         = (level_q == LEVEL_FULL) & bus.wr_en & ~load;
        wr_expected  = rd_ptr_q + level_q[ADDR_W-1:0];
        ptr_mismatch = bus.wr_en & (bus.wr_addr != wr_expected);
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        if (load | drop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        level_d = level_q;
        if (!drop) begin
            if (bus.wr_en && !load) begin
                level_d = level_q + (ADDR_W+1)'(1);
            end else if (load && !bus.wr_en) begin
                level_d = level_q - (ADDR_W+1)'(1);
            end
        end

        out_data_d  = load ? bus.mem_rd_data : out_data_q;
        out_valid_d = load | (out_valid_q & ~pop);

        // A set condition in the same cycle as clr_flags wins.
        overrun_d = drop | (overrun_q & ~clr_flags);
        ptr_err_d = ptr_mismatch | (ptr_err_q & ~clr_flags);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            ptr_err_q   <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            ptr_err_q   <= ptr_err_d;
        end
    end

    assign bus.mem_rd_addr = rd_ptr_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = out_valid_q;
    assign level           = level_q;
    assign overrun         = overrun_q;
    assign ptr_err         = ptr_err_q;
endmodule

// File: tb/tb_mem_array_reader.sv
// Bench for mem_array_reader: a writer/array model, a queue-based reference of the byte stream,
// and a negedge monitor that scores every handshake and status output.
module tb_mem_array_reader;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              clr_flags = 1'b0;
    logic [ADDR_W:0]   level;
    logic              overrun;
    logic              ptr_err;
    logic [DATA_W-1:0] wr_data   = '0;
    logic [ADDR_W-1:0] wr_ptr    = '0;
    logic [ADDR_W-1:0] addr_skew = '0;
    logic [DATA_W-1:0] mem [DEPTH];

    int n_checks = 0;
    int n_pass   = 0;

    mem_array_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mem_array_reader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.master),
        .clr_flags (clr_flags),
        .level     (level),
        .overrun   (overrun),
        .ptr_err   (ptr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Writer and array: clocked write, combinational read.
    initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    assign bus.wr_addr     = wr_ptr + addr_skew;
    assign bus.mem_rd_data = mem[bus.mem_rd_addr];
    always @(posedge clk) if (rst_n && bus.wr_en) mem[bus.wr_addr] <= wr_data;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) wr_ptr <= '0;
        else if (bus.wr_en) wr_ptr <= wr_ptr + 1'b1;

    // Reference: sb holds every byte written but not yet delivered, in delivery order.
    // held_m says the head of sb sits in out_data; level_m counts the rest.
    logic [DATA_W-1:0] sb [$];
    int level_m     = 0;
    bit held_m      = 0;
    bit ovr_flag_m  = 0;
    bit perr_flag_m = 0;
    bit m_pop, m_load, m_ovr, m_perr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_m = 0; held_m = 0; ovr_flag_m = 0; perr_flag_m = 0;
            sb.delete();
        end else begin
            m_pop  = held_m && bus.out_ready;
            m_load = (!held_m || m_pop) && level_m > 0;
            m_ovr  = level_m == DEPTH && bus.wr_en && !m_load;
            m_perr = bus.wr_en && (bus.wr_addr != wr_ptr);
            if (m_ovr) sb.delete(1);
            else level_m = level_m + (bus.wr_en ? 1 : 0) - (m_load ? 1 : 0);
            if (m_load) held_m = 1;
            else if (m_pop) held_m = 0;
            if (bus.wr_en) sb.push_back(wr_data);
            ovr_flag_m  = m_ovr  || (ovr_flag_m  && !clr_flags);
            perr_flag_m = m_perr || (perr_flag_m && !clr_flags);
        end
    end

    // Monitor: inputs are stable here, so a handshake now will complete at the next edge.
    always @(negedge clk) begin
        logic [DATA_W-1:0] exp_byte;
        check("out_valid", 32'(bus.out_valid), 32'(held_m));
        check("level", 32'(level), 32'(level_m));
        check("overrun", 32'(overrun), 32'(ovr_flag_m));
        check("ptr_err", 32'(ptr_err), 32'(perr_flag_m));
        if (bus.out_valid && bus.out_ready) begin
            check("data_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_byte = sb.pop_front();
                check("out_data", 32'(bus.out_data), 32'(exp_byte));
            end
        end
    end

    task automatic drive(input bit we, input logic [DATA_W-1:0] d, input bit rdy, input bit clr = 1'b0);
        @(posedge clk);
        #1;
        bus.wr_en     = we;
        wr_data       = d;
        bus.out_ready = rdy;
        clr_flags     = clr;
    endtask

    // Reset pulse placed between clock edges; outputs must clear without waiting for clk.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        bus.wr_en     = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        #1;
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_data"}, 32'(bus.out_data), 32'd0);
        check({tag, "_level"}, 32'(level), 32'd0);
        #9;
        rst_n = 1'b1;
    endtask

    initial begin
        int wprob, rprob;
        bus.wr_en     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_flags", 32'({overrun, ptr_err}), 32'd0);
        rst_n = 1'b1;

        // Three bytes streamed with the consumer always ready.
        drive(1, 8'h11, 1);
        drive(1, 8'h22, 1);
        check("lat_not_yet", 32'(bus.out_valid), 32'd0);
        drive(1, 8'h33, 1);
        check("lat_first_valid", 32'(bus.out_valid), 32'd1);
        check("lat_first_data", 32'(bus.out_data), 32'h11);
        repeat (4) drive(0, 8'h00, 1);

        // Fill with the consumer stalled: the first byte moves to out_data.
        for (int i = 0; i < 16; i++) drive(1, 8'(i), 0);
        drive(0, 8'h00, 0);
        check("fill_level", 32'(level), 32'd15);
        check("fill_data", 32'(bus.out_data), 32'h00);
        check("fill_ovr", 32'(overrun), 32'd0);
        drive(1, 8'hAA, 0);
        drive(0, 8'h00, 0);
        check("full_level", 32'(level), 32'd16);
        check("full_ovr", 32'(overrun), 32'd0);
        drive(1, 8'hBB, 0);
        drive(0, 8'h00, 0);
        check("ovr_level", 32'(level), 32'd16);
        check("ovr_flag", 32'(overrun), 32'd1);
        drive(0, 8'h00, 0, 1);

        // Full, with reads and writes every cycle across the pointer wrap.
        for (int i = 0; i < 40; i++) drive(1, 8'(8'h40 + i), 1);
        drive(0, 8'h00, 1);
        check("steady_level", 32'(level), 32'd16);
        check("steady_ovr", 32'(overrun), 32'd0);
        repeat (20) drive(0, 8'h00, 1);
        check("drained_level", 32'(level), 32'd0);

        // Writer address off by one during a write.
        drive(1, 8'h77, 0);
        addr_skew = 4'd1;
        drive(0, 8'h00, 0);
        addr_skew = 4'd0;
        check("perr_set", 32'(ptr_err), 32'd1);
        drive(0, 8'h00, 0, 1);
        drive(0, 8'h00, 0);
        check("perr_clr", 32'({overrun, ptr_err}), 32'd0);
        async_reset("rst_a");

        // Reset in the middle of a drain, then a fresh byte.
        for (int i = 0; i < 8; i++) drive(1, 8'($urandom), 0);
        repeat (3) drive(0, 8'h00, 1);
        async_reset("rst_b");
        drive(1, 8'h5C, 1);
        drive(0, 8'h00, 1);
        drive(0, 8'h00, 1);
        check("post_rst_data", 32'(bus.out_data), 32'h5C);
        check("post_rst_valid", 32'(bus.out_valid), 32'd1);

        // Random traffic with shifting write/read pressure.
        wprob = 50; rprob = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                wprob = $urandom_range(10, 100);
                rprob = $urandom_range(10, 100);
            end
            drive($urandom_range(0, 99) < wprob, 8'($urandom),
                  $urandom_range(0, 99) < rprob, $urandom_range(0, 99) == 0);
        end
        repeat (40) drive(0, 8'h00, 1);
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        check("final_level", 32'(level), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
